// File: rtl/display_pkg.sv
// Shared display definitions for the keypad scanner and the display mux.
// Holds the digit and segment widths, the slot type, the blank pattern and the
// active-low {g,f,e,d,c,b,a} encoding table for the hex digits 0..F.
package display_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEG_W   = 7;

   typedef enum logic {
      SLOT_RIGHT = 1'b0,
      SLOT_LEFT  = 1'b1
   } slot_t;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   // Indexed by the hex value; a segment is lit when its bit is 0.
   localparam logic [SEG_W-1:0] SEG_CODES [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/keypad_display_if.sv
// Bundle between the keypad producer and the display consumer.
//   digit, valid_key : key value and one-cycle capture strobe (producer -> display)
//   seg              : active-low segment bus {g,f,e,d,c,b,a}
//   an_left_n/right_n: active-low anode enables
//   num_keys         : saturating count of captured keys (0..2)
// master = keypad side, slave = display side.
interface keypad_display_if;
   import display_pkg::*;

   logic [DIGIT_W-1:0] digit;
   logic               valid_key;
   logic [SEG_W-1:0]   seg;
   logic               an_left_n;
   logic               an_right_n;
   logic [1:0]         num_keys;

   modport master (
      output digit, valid_key,
      input  seg, an_left_n, an_right_n, num_keys
   );

   modport slave (
      input  digit, valid_key,
      output seg, an_left_n, an_right_n, num_keys
   );

endinterface

// File: rtl/seven_seg_decoder.sv
// Combinational hex to active-low seven-segment decoder.
//   digit : 4-bit hex value
//   seg   : active-low segments {g,f,e,d,c,b,a}
module seven_seg_decoder
   import display_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [SEG_W-1:0]   seg
);

   assign seg = SEG_CODES[digit];

endmodule

// File: rtl/keypad_display.sv
// Two-digit keypad display: keeps the last two keys and time-multiplexes them
// onto a dual common-anode seven-segment display (newest key on the right).
//   clk, reset : system clock, synchronous active-low reset
//   bus        : slave side of keypad_display_if (digit/valid_key in,
//                seg/an_left_n/an_right_n/num_keys out, all outputs registered)
module keypad_display
   import display_pkg::*;
#(
   parameter logic [15:0] MUX_DIVIDER = 16'd20000,
   parameter logic [15:0] DEAD_CYCLES = 16'd2
) (
   input logic               clk,
   input logic               reset,
   keypad_display_if.slave   bus
);

   logic [15:0]        cnt_q, cnt_d;
   slot_t              slot_q, slot_d;
   logic [DIGIT_W-1:0] recent_q, recent_d, prev_q, prev_d;
   logic               recent_vld_q, recent_vld_d, prev_vld_q, prev_vld_d;
   logic [1:0]         num_keys_q, num_keys_d;
   logic [SEG_W-1:0]   seg_q, seg_d;
   logic               an_left_q, an_left_d, an_right_q, an_right_d;

   logic [DIGIT_W-1:0] mux_digit;
   logic               mux_vld;
   logic [SEG_W-1:0]   dec_seg;

   // State register, including the registered output stage.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q        <= '0;
         slot_q       <= SLOT_RIGHT;
         recent_q     <= '0;
         prev_q       <= '0;
         recent_vld_q <= 1'b0;
         prev_vld_q   <= 1'b0;
         num_keys_q   <= 2'd0;
         seg_q        <= SEG_BLANK;
         an_left_q    <= 1'b1;
         an_right_q   <= 1'b1;
      end else begin
         cnt_q        <= cnt_d;
         slot_q       <= slot_d;
         recent_q     <= recent_d;
         prev_q       <= prev_d;
         recent_vld_q <= recent_vld_d;
         prev_vld_q   <= prev_vld_d;
         num_keys_q   <= num_keys_d;
         seg_q        <= seg_d;
         an_left_q    <= an_left_d;
         an_right_q   <= an_right_d;
      end
   end

   // Next state: mux timing and key capture are independent and may share an edge.
   always_comb begin
      cnt_d        = cnt_q + 16'd1;
      slot_d       = slot_q;
      recent_d     = recent_q;
      prev_d       = prev_q;
      recent_vld_d = recent_vld_q;
      prev_vld_d   = prev_vld_q;
      num_keys_d   = num_keys_q;

      if (cnt_q == MUX_DIVIDER - 16'd1) begin
         cnt_d  = '0;
         slot_d = (slot_q == SLOT_RIGHT) ? SLOT_LEFT : SLOT_RIGHT;
      end

      if (bus.valid_key) begin
         prev_d       = recent_q;
         prev_vld_d   = recent_vld_q;
         recent_d     = bus.digit;
         recent_vld_d = 1'b1;
         if (num_keys_q != 2'd2) begin
            num_keys_d = num_keys_q + 2'd1;
         end
      end
   end

   // Output decode from current state; registered above for one cycle of latency.
   always_comb begin
      mux_digit  = (slot_q == SLOT_LEFT) ? prev_q : recent_q;
      mux_vld    = (slot_q == SLOT_LEFT) ? prev_vld_q : recent_vld_q;
      seg_d      = mux_vld ? dec_seg : SEG_BLANK;
      an_left_d  = 1'b1;
      an_right_d = 1'b1;
      // Both anodes stay off for the first cycles of a slot to avoid ghosting.
      if (cnt_q >= DEAD_CYCLES) begin
         if (slot_q == SLOT_LEFT) begin
            an_left_d = 1'b0;
         end else begin
            an_right_d = 1'b0;
         end
      end
   end

   seven_seg_decoder u_decoder (
      .digit (mux_digit),
      .seg   (dec_seg)
   );

   assign bus.seg        = seg_q;
   assign bus.an_left_n  = an_left_q;
   assign bus.an_right_n = an_right_q;
   assign bus.num_keys   = num_keys_q;

endmodule

// File: tb/tb_keypad_display.sv
// Bench for keypad_display: directed scenarios then random keys and resets,
// compared every cycle against a time-based reference model.
module tb_keypad_display;

   localparam int MD = 8;
   localparam int DC = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   keypad_display_if bus ();

   keypad_display #(
      .MUX_DIVIDER (16'(MD)),
      .DEAD_CYCLES (16'(DC))
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [6:0] ref_seg [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   int checks = 0;
   int errors = 0;

   // Reference state: keys captured since reset (newest last, at most two) and
   // number of running edges since reset.
   int keys [$];
   int n = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, predict the registered outputs, compare after the edge.
   task automatic step(input logic rst_n, input logic v, input logic [3:0] d);
      logic [6:0] e_seg;
      logic       e_l, e_r;
      int         e_nk, cnt, slot;
      @(negedge clk);
      reset         = rst_n;
      bus.valid_key = v;
      bus.digit     = d;
      e_seg = 7'h7f;
      e_l   = 1'b1;
      e_r   = 1'b1;
      if (!rst_n) begin
         keys.delete();
         n    = 0;
         e_nk = 0;
      end else begin
         cnt  = n % MD;
         slot = (n / MD) % 2;  // 0 = right, 1 = left
         if (cnt >= DC) begin
            if (slot == 0) e_r = 1'b0;
            else           e_l = 1'b0;
         end
         if (slot == 0 && keys.size() >= 1) e_seg = ref_seg[keys[keys.size()-1]];
         if (slot == 1 && keys.size() >= 2) e_seg = ref_seg[keys[keys.size()-2]];
         if (v) begin
            keys.push_back(int'(d));
            if (keys.size() > 2) void'(keys.pop_front());
         end
         n++;
         e_nk = keys.size();
      end
      @(posedge clk);
      #1;
      check($sformatf("seg n=%0d", n), 32'(bus.seg), 32'(e_seg));
      check($sformatf("an_left n=%0d", n), 32'(bus.an_left_n), 32'(e_l));
      check($sformatf("an_right n=%0d", n), 32'(bus.an_right_n), 32'(e_r));
      check($sformatf("num_keys n=%0d", n), 32'(bus.num_keys), 32'(e_nk));
      check($sformatf("exclusive n=%0d", n), 32'(bus.an_left_n | bus.an_right_n), 32'd1);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 4'h0);
   endtask

   initial begin
      logic       v;
      logic       last_v;
      logic [3:0] d;
      bus.valid_key = 1'b0;
      bus.digit     = 4'h0;

      // Reset with a key offered during reset (must be ignored).
      step(1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b1, 4'h7);
      step(1'b0, 1'b0, 4'h0);
      idle(20);

      // Single key, then two keys, then a third.
      step(1'b1, 1'b1, 4'h5);
      idle(20);
      step(1'b1, 1'b1, 4'hA);
      idle(3);
      step(1'b1, 1'b1, 4'h3);
      idle(20);
      step(1'b1, 1'b1, 4'hF);
      idle(64);

      // Capture on the wrap edge; loop is bounded by MD steps.
      for (int i = 0; i < MD && (n % MD) != MD - 1; i++) step(1'b1, 1'b0, 4'h0);
      step(1'b1, 1'b1, 4'h8);
      idle(20);

      // Mid-operation reset after two keys.
      step(1'b1, 1'b1, 4'h2);
      step(1'b1, 1'b1, 4'h9);
      idle(5);
      step(1'b0, 1'b0, 4'h0);
      idle(20);

      // Random keys (never back-to-back) and occasional resets.
      last_v = 1'b0;
      for (int i = 0; i < 600; i++) begin
         v = !last_v && ($urandom_range(0, 4) == 0);
         d = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 149) == 0) begin
            step(1'b0, v, d);
            last_v = 1'b0;
         end else begin
            step(1'b1, v, d);
            last_v = v;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_display.md
Name: keypad_display

Overview:
- Consumer end of the keypad scanner interface. Accepts the scanner's one-cycle `valid_key` pulse and its 4-bit hex `digit`.
- Keeps the two most recent keys: newest on the right display, previous on the left.
- Time-multiplexes a dual common-anode seven-segment display: one shared segment bus, two active-low anode enables.
- Sits between the keypad FSM and the board pins.

Parameters:
- MUX_DIVIDER, 16'd20000: clk cycles per display slot (left or right). Must be >= 4.
- DEAD_CYCLES, 16'd2: cycles at the start of each slot with both anodes off (anti-ghosting). Must be < MUX_DIVIDER.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- digit  in  4  hex value of the pressed key, valid only when valid_key=1
- valid_key  in  1  one-cycle pulse per accepted key press
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- an_left_n  out  1  left display enable, active-low
- an_right_n  out  1  right display enable, active-low
- num_keys  out  2  saturating count of keys captured since reset: 0, 1, 2

Behaviour:
- Reset (reset=0 at a rising edge):
  - recent=0, prev=0, recent_vld=0, prev_vld=0, mux counter=0, slot=RIGHT, num_keys=0.
  - Registered outputs: seg=7'b1111111, an_left_n=1, an_right_n=1.
  - Reset mid-operation discards stored digits and blanks both displays.
- Capture: on any rising edge with valid_key=1:
  - prev<=recent, prev_vld<=recent_vld, recent<=digit, recent_vld<=1.
  - num_keys increments and saturates at 2.
  - No edge detection: every high cycle is a capture. Upstream guarantees one-cycle pulses.
- Mux counter:
  - Counts 0..MUX_DIVIDER-1.
  - At terminal count it wraps to 0 and slot toggles RIGHT<->LEFT.
  - First slot after reset is RIGHT.
- Output stage (all outputs registered, 1-cycle latency from internal state):
  - When counter < DEAD_CYCLES: an_left_n=an_right_n=1.
  - Otherwise: the anode of the current slot = 0 and the other = 1.
  - seg = decode(slot digit) if that slot's vld=1, else 7'b1111111 (blank).
  - A slot with vld=0 is blank even while its anode is enabled.
- Latency: a capture at edge k appears on seg at edge k+1 if the RIGHT slot is active past its dead time.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events:
  - Capture coinciding with a slot toggle: both take effect at the same edge. The next output cycle is a dead-time cycle, then shows new data.
  - valid_key asserted during reset: ignored.
- Invariant: never both anodes low in the same cycle.

Decomposition:
- Shared package display_pkg:
  - slot_t enum {SLOT_RIGHT, SLOT_LEFT}.
  - SEG_BLANK constant.
  - 16-entry segment encoding constants.
  - Shared with the keypad FSM for the 4-bit digit width.
- One sub-module, seven_seg_decoder: purely combinational, 4-bit in, 7-bit active-low out.
- Instantiate it once, on the muxed digit.

Test Plan:
- Test parameters: MUX_DIVIDER=8, DEAD_CYCLES=2.
- Reset:
  - Stimulus: hold reset=0 for 3 cycles, then release.
  - Required: seg=1111111, both anodes=1, num_keys=0.
  - For 20 cycles after release: seg stays 1111111 even when an_right_n=0 (cycles 3-8 after release).
- Single key:
  - Stimulus: pulse valid_key with digit=4'h5.
  - Required: num_keys=1. Within the next RIGHT slot, seg=0010010 while an_right_n=0.
  - Left slot stays blank (seg=1111111 while an_left_n=0).
- Two keys:
  - Stimulus: pulses with digit=4'hA, then digit=4'h3.
  - Required: LEFT shows 0001000, RIGHT shows 0110000, num_keys=2.
  - Third key 4'hF: LEFT=0110000, RIGHT=0001110, num_keys stays 2.
- Dead time and exclusivity:
  - Stimulus: run 64 cycles.
  - Required: every slot begins with exactly 2 cycles of both anodes=1, then 6 cycles with one anode=0. an_left_n|an_right_n==1 on every cycle.
- Collision:
  - Stimulus: valid_key with digit=4'h8 on the edge where the counter wraps.
  - Required: the capture is not lost. After dead time, RIGHT shows 0000000.
- Mid-operation reset:
  - Stimulus: after two keys, assert reset=0 for 1 cycle.
  - Required: next cycle both anodes=1, seg=1111111, num_keys=0, and both slots stay blank afterwards.
